round_robin: RTL and testbench

Five-input round-robin arbiter for one output port of the mesh NoC router. Each input port (Local, North, East, South, West) presents the output-direction code its head flit wants. The block grants the output named by `direction` to exactly one matching input per cycle, rotating priority fairly. One instance sits in front of each router output crossbar leg, and `select` drives the crossbar mux.

---
 rtl/round_robin.sv | 93 +++++++++
 tb/tb_round_robin.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/round_robin.sv
// Five-input round-robin arbiter for one router output port; select drives the crossbar mux.
// Optional packet lock is enabled by defining RR_LOCK_EN.
module round_robin (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] request_L,
    input  logic [2:0] request_N,
    input  logic [2:0] request_E,
    input  logic [2:0] request_S,
    input  logic [2:0] request_W,
    input  logic [2:0] direction,
    output logic [2:0] select
);

    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_W    = 3'b101;

    logic [2:0] select_q, select_d;
    logic [2:0] last_q, last_d;
    logic       dir_valid;
    logic [4:0] elig;        // bit 0 = L ... bit 4 = W
    logic [2:0] last_idx;
    logic [3:0] cand;
    logic       found;
    logic       hold;

    assign dir_valid = (direction >= 3'b001) && (direction <= 3'b101);

    always_comb begin
        elig[0] = dir_valid && (request_L == direction);
        elig[1] = dir_valid && (request_N == direction);
        elig[2] = dir_valid && (request_E == direction);
        elig[3] = dir_valid && (request_S == direction);
        elig[4] = dir_valid && (request_W == direction);
    end

    // The currently granted input still asks for this output.
    always_comb begin
        hold = 1'b0;
        case (select_q)
            3'b001:  hold = elig[0];
            3'b010:  hold = elig[1];
            3'b011:  hold = elig[2];
            3'b100:  hold = elig[3];
            3'b101:  hold = elig[4];
            default: hold = 1'b0;
        endcase
    end

    // select is valid for exactly the cycle after the sampling edge; no handshake.
    always_comb begin
        select_d = CODE_NONE;
        last_d   = last_q;
        found    = 1'b0;
        cand     = 4'd0;
        last_idx = last_q - 3'd1;
        for (int k = 1; k <= 5; k++) begin
            cand = {1'b0, last_idx} + 4'(k);
            if (cand >= 4'd5) begin
                cand = cand - 4'd5;
            end
            if (!found && elig[cand[2:0]]) begin
                found    = 1'b1;
                select_d = cand[2:0] + 3'd1;
                last_d   = cand[2:0] + 3'd1;
            end
        end
`ifdef RR_LOCK_EN
        if (hold) begin
            select_d = select_q;
            last_d   = last_q;
        end
`else
        if (hold) begin
            // Without the lock every cycle re-arbitrates; hold is unused.
            select_d = select_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            select_q <= CODE_NONE;
            last_q   <= CODE_W;
        end else begin
            select_q <= select_d;
            last_q   <= last_d;
        end
    end

    assign select = select_q;

endmodule

// File: tb/tb_round_robin.sv
// Scoreboard bench for round_robin: driver pushes model-predicted select values, monitor pops and compares.
module tb_round_robin;

  logic       clk;
  logic       rst;
  logic [2:0] request_L, request_N, request_E, request_S, request_W;
  logic [2:0] direction;
  logic [2:0] select;

  logic [2:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  // reference model state: last granted port index 0..4 (L..W), current grant code
  int         m_last;
  logic [2:0] m_sel;

  round_robin dut (
    .clk       (clk),
    .rst       (rst),
    .request_L (request_L),
    .request_N (request_N),
    .request_E (request_E),
    .request_S (request_S),
    .request_W (request_W),
    .direction (direction),
    .select    (select)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one arbitration step from the rules, on plain arrays
  task automatic model_step(input logic r, input logic [2:0] req[5], input logic [2:0] d);
    int order[$];
    logic granted;
    if (!r) begin
      m_sel  = 3'b000;
      m_last = 4;
      return;
    end
    if (d == 3'd0 || d > 3'd5) begin
      m_sel = 3'b000;
      return;
    end
`ifdef RR_LOCK_EN
    if (m_sel != 3'b000 && req[m_sel - 1] == d) begin
      return;
    end
`endif
    for (int k = 1; k <= 5; k++) order.push_back((m_last + k) % 5);
    granted = 1'b0;
    foreach (order[i]) begin
      if (!granted && req[order[i]] == d) begin
        granted = 1'b1;
        m_last  = order[i];
      end
    end
    m_sel = granted ? 3'(m_last + 1) : 3'b000;
  endtask

  // driver: apply inputs away from the edge, predict, wait for the edge
  task automatic drive(input logic r, input logic [2:0] l, n, e, s, w, d);
    logic [2:0] req[5];
    @(negedge clk);
    rst = r; request_L = l; request_N = n; request_E = e;
    request_S = s; request_W = w; direction = d;
    req[0] = l; req[1] = n; req[2] = e; req[3] = s; req[4] = w;
    model_step(r, req, d);
    exp_q.push_back(m_sel);
    @(posedge clk);
  endtask

  // monitor: compare every cycle for which an expectation exists
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [2:0] exp_v;
      exp_v = exp_q.pop_front();
      checks++;
      if (select !== exp_v) begin
        errors++;
        $display("FAIL select t=%0t got=%b exp=%b", $time, select, exp_v);
      end
    end
  end

  function automatic logic [2:0] rand_req(input logic [2:0] d);
    if ($urandom_range(0, 1) == 0) return d;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [2:0] d;
    m_sel = 3'b000; m_last = 4;
    rst = 1'b0; request_L = 0; request_N = 0; request_E = 0;
    request_S = 0; request_W = 0; direction = 0;

    // reset and rotation
    drive(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    repeat (5) drive(1'b1, 3'd1, 3'd0, 3'd1, 3'd3, 3'd1, 3'd1);
    // lock release / rotation with L dropped, then E dropped
    drive(1'b1, 3'd0, 3'd0, 3'd1, 3'd3, 3'd1, 3'd1);
    drive(1'b1, 3'd1, 3'd0, 3'd0, 3'd3, 3'd1, 3'd1);
    drive(1'b1, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 3'd1);
    // no match, then direction 010, then invalid direction
    repeat (2) drive(1'b1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1);
    repeat (3) drive(1'b1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2);
    drive(1'b1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
    drive(1'b1, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6);
    drive(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    // single requester
    repeat (4) drive(1'b1, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd4);
    // reset mid-rotation, then L first
    drive(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    repeat (3) drive(1'b1, 3'd1, 3'd0, 3'd1, 3'd3, 3'd1, 3'd1);
    drive(1'b0, 3'd1, 3'd0, 3'd1, 3'd3, 3'd1, 3'd1);
    repeat (3) drive(1'b1, 3'd1, 3'd0, 3'd1, 3'd3, 3'd1, 3'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) d = 3'($urandom_range(1, 5));
      else d = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 39) != 0), rand_req(d), rand_req(d), rand_req(d),
            rand_req(d), rand_req(d), d);
    end

    // drain, then confirm every expectation was consumed
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
